// File: rtl/adder_pkg.sv
// adder_pkg: shared defaults and result type for the board-level full adder.
//   SYNC_STAGES_DEF      default synchroniser depth per switch
//   DEBOUNCE_CYCLES_DEF  default debounce hold time in clocks (0 = bypass)
//   LED_ACTIVE_LOW_DEF   default LED polarity (0 = LED lit on 1)
//   adder_result_t       {carry, sum} of a 1-bit full add
//   full_add()           combinational full adder producing adder_result_t
package adder_pkg;

  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam bit          LED_ACTIVE_LOW_DEF  = 1'b0;

  typedef struct packed {
    logic carry;
    logic sum;
  } adder_result_t;

  function automatic adder_result_t full_add(input logic a, input logic b, input logic cin);
    adder_result_t r;
    r.sum   = a ^ b ^ cin;
    r.carry = (a & b) | (a & cin) | (b & cin);
    return r;
  endfunction

endpackage

// File: rtl/adder_switch_debounce.sv
// switch_debounce: one-bit synchroniser chain followed by a debounce counter.
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset; clears chain, level and counter
//   raw_in     in   switch level, asynchronous to clk
//   level_out  out  accepted (debounced) level
// A changed synchronised level must persist for DEBOUNCE_CYCLES clocks before
// it is accepted; any return to the accepted level restarts the count.
// DEBOUNCE_CYCLES == 0 passes the synchronised level straight through.
module switch_debounce
  import adder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic level_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   sync_s;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign level_out = sync_s;
  end else begin : g_debounce
    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;

    // The edge on which cnt already equals DEBOUNCE_CYCLES-1 is the
    // DEBOUNCE_CYCLES-th consecutive mismatch, so it commits the new level.
    always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      if (sync_s == level_q) begin
        cnt_d = '0;
      end else if (cnt_q >= CNT_LAST) begin
        level_d = sync_s;
        cnt_d   = '0;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q   <= '0;
        level_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        level_q <= level_d;
      end
    end

    assign level_out = level_q;
  end

endmodule

// File: rtl/adder.sv
// adder: board-level 1-bit full adder for the Cyclone 10 demo board.
//   clk       in   system clock, sole clock domain
//   rst_n     in   asynchronous active-low reset
//   switch_0  in   operand A (asynchronous)
//   switch_1  in   operand B (asynchronous)
//   switch_2  in   carry-in (asynchronous)
//   led_0     out  registered sum, inverted when LED_ACTIVE_LOW
//   led_1     out  registered carry-out, inverted when LED_ACTIVE_LOW
// Each switch is synchronised and debounced, the three accepted levels are
// added, and the result is registered before driving the LEDs.
module adder
  import adder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter bit          LED_ACTIVE_LOW  = LED_ACTIVE_LOW_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic switch_0,
  input  logic switch_1,
  input  logic switch_2,
  output logic led_0,
  output logic led_1
);

  logic          level_a;
  logic          level_b;
  logic          level_cin;
  adder_result_t res_d;
  adder_result_t res_q;

  switch_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw_in   (switch_0),
    .level_out(level_a)
  );

  switch_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw_in   (switch_1),
    .level_out(level_b)
  );

  switch_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_cin (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw_in   (switch_2),
    .level_out(level_cin)
  );

  always_comb begin
    res_d = full_add(level_a, level_b, level_cin);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  // Polarity is a constant, so the LEDs remain a pure function of flops.
  assign led_0 = res_q.sum   ^ LED_ACTIVE_LOW;
  assign led_1 = res_q.carry ^ LED_ACTIVE_LOW;

endmodule

// File: tb/tb_adder.sv
// tb_adder: directed testbench for adder (default polarity) alongside an
// active-low-LED instance driven by the same clock, reset and switches.
module tb_adder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sw0   = 1'b0;
  logic sw1   = 1'b0;
  logic sw2   = 1'b0;
  logic led0, led1;
  logic led0_n, led1_n;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  adder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .switch_0(sw0),
    .switch_1(sw1),
    .switch_2(sw2),
    .led_0   (led0),
    .led_1   (led1)
  );

  adder #(
    .LED_ACTIVE_LOW(1'b1)
  ) dut_n (
    .clk     (clk),
    .rst_n   (rst_n),
    .switch_0(sw0),
    .switch_1(sw1),
    .switch_2(sw2),
    .led_0   (led0_n),
    .led_1   (led1_n)
  );

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // advance one rising edge and sample just after it
  task automatic edge_s();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sw(input logic [2:0] v);
    @(negedge clk);
    {sw2, sw1, sw0} = v;
  endtask

  task automatic settle(input logic [2:0] v);
    set_sw(v);
    repeat (9) edge_s();
  endtask

  logic [1:0] tt_exp [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tt_exp[0] = 2'b00; tt_exp[1] = 2'b01; tt_exp[2] = 2'b01; tt_exp[3] = 2'b10;
    tt_exp[4] = 2'b01; tt_exp[5] = 2'b10; tt_exp[6] = 2'b10; tt_exp[7] = 2'b11;

    // reset held with all switches on
    {sw2, sw1, sw0} = 3'b111;
    repeat (4) begin
      edge_s();
      check("rst_hold", {led1, led0}, 2'b00);
      check("rst_hold_pol", {led1_n, led0_n}, 2'b11);
    end

    // release: nothing changes until the 7th edge, then 11 (00 inverted)
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      edge_s();
      check("release", {led1, led0}, (k == 7) ? 2'b11 : 2'b00);
      check("release_pol", {led1_n, led0_n}, (k == 7) ? 2'b00 : 2'b11);
    end

    // asynchronous assert between edges drops LEDs at once
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst", {led1, led0}, 2'b00);
    check("async_rst_pol", {led1_n, led0_n}, 2'b11);
    @(negedge clk);
    {sw2, sw1, sw0} = 3'b000;
    rst_n = 1'b1;
    repeat (9) edge_s();
    check("idle_zero", {led1, led0}, 2'b00);

    // truth table
    for (int v = 0; v < 8; v++) begin
      settle(3'(v));
      check($sformatf("tt_%0d", v), {led1, led0}, tt_exp[v]);
      check($sformatf("tt_pol_%0d", v), {led1_n, led0_n}, ~tt_exp[v]);
    end

    // latency: s0 0->1, led_0 on exactly the 7th edge
    settle(3'b000);
    set_sw(3'b001);
    for (int k = 1; k <= 7; k++) begin
      edge_s();
      check($sformatf("lat_%0d", k), {led1, led0}, (k == 7) ? 2'b01 : 2'b00);
    end

    // bounce on s1: 2-clock pulses 1,0 then hold 1
    settle(3'b000);
    set_sw(3'b010);
    repeat (2) begin
      edge_s();
      check("bounce_hi", {led1, led0}, 2'b00);
    end
    set_sw(3'b000);
    repeat (2) begin
      edge_s();
      check("bounce_lo", {led1, led0}, 2'b00);
    end
    set_sw(3'b010);
    for (int k = 1; k <= 7; k++) begin
      edge_s();
      check($sformatf("bounce_hold_%0d", k), {led1, led0}, (k == 7) ? 2'b01 : 2'b00);
    end
    repeat (3) begin
      edge_s();
      check("bounce_stable", {led1, led0}, 2'b01);
    end

    // reset during an in-progress debounce of s2
    settle(3'b000);
    set_sw(3'b100);
    repeat (4) begin
      edge_s();
      check("midop_pre", {led1, led0}, 2'b00);
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midop_rst", {led1, led0}, 2'b00);
    check("midop_rst_pol", {led1_n, led0_n}, 2'b11);
    repeat (2) begin
      edge_s();
      check("midop_hold", {led1, led0}, 2'b00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      edge_s();
      check($sformatf("midop_rel_%0d", k), {led1, led0}, (k == 7) ? 2'b01 : 2'b00);
      check($sformatf("midop_rel_pol_%0d", k), {led1_n, led0_n}, (k == 7) ? 2'b10 : 2'b11);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
